if_stage_pc_unit: RTL and testbench
===================================

# if_stage_pc_unit

Instruction-fetch stage of the 5-stage RV32I pipeline. It holds the program counter (PC), which is loaded each cycle from the PC-select 2:1 mux, and produces PC+4 as that mux's sequential input. It presents the fetch address to instruction memory and captures the returned instruction into the IF/ID pipeline register. Stall, flush and instruction-memory wait states are all resolved here, so the decode stage sees a clean instruction/valid pair.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction inserted into IF/ID on a bubble (addi x0,x0,0)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_next  in  32  next PC from the PC-select mux (PC+4 or branch/jump target)
- pc_plus4  out  32  pc_f + 4, combinational, drives the mux's select-0 input
- pc_f  out  32  current fetch address to instruction memory
- imem_req  out  1  fetch request; high only in the RUN state
- imem_rdata  in  32  instruction at pc_f
- imem_valid  in  1  imem_rdata is valid this cycle; low means memory wait state
- stall_f  in  1  hazard unit: hold PC
- stall_d  in  1  hazard unit: hold IF/ID
- flush_d  in  1  hazard unit: branch/jump taken; squash IF/ID and redirect PC
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- stall_cnt  out  16  saturating count of cycles lost to imem_valid=0 while imem_req=1

## Operation
- FSM has two states, BOOT and RUN. Reset enters BOOT. BOOT always moves to RUN on the next edge. RUN holds until reset.
- imem_req = (state == RUN).
- fetch_ok = imem_req & imem_valid.
- pc_plus4 = pc_f + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- PC update, in priority order:
  1. flush_d=1 (in RUN) -> pc_f <= pc_next, regardless of stall_f and imem_valid.
  2. stall_f=1 -> hold.
  3. fetch_ok -> pc_f <= pc_next.
  4. Otherwise hold.
- In BOOT the PC always holds.
- IF/ID update, in priority order:
  1. flush_d=1 -> instr_d=NOP_INSTR, valid_d=0; pc_d and pc_plus4_d are don't-care, implemented as hold.
  2. stall_d=1 -> hold all four registers.
  3. fetch_ok -> instr_d=imem_rdata, pc_d=pc_f, pc_plus4_d=pc_plus4, valid_d=1.
  4. Otherwise (wait state or BOOT) -> bubble: instr_d=NOP_INSTR, valid_d=0.
- Corner case stall_f=0 with stall_d=1: the PC advances only if fetch_ok. The hazard unit never issues this combination; the block still applies the rules above without special handling.
- stall_cnt increments when imem_req=1 and imem_valid=0 and stall_f=0. It saturates at 16'hFFFF and never wraps.

## Timing
- Reset values (asynchronous): state=BOOT, pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, stall_cnt=0. imem_req is 0 during reset and in the BOOT cycle.
- First request: imem_req rises on the first edge after rst deasserts, at the BOOT->RUN transition.
- Latency: an instruction fetched at edge N (fetch_ok high before N) appears on instr_d/valid_d after edge N. Throughput is one instruction per cycle when imem_valid is held high.
- Redirect: flush_d sampled high at edge N -> pc_f=pc_next and valid_d=0 after edge N. The target's instruction reaches IF/ID after edge N+1 at the earliest.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). The previously fetched instruction is lost.

## Test plan
- Reset/boot: RESET_PC=0x100, imem_valid=1, deassert rst -> BOOT cycle with imem_req=0 and valid_d=0; then pc_f steps 0x100, 0x104, 0x108; instr_d follows one cycle later with valid_d=1.
- Wait states: imem_valid low for 3 cycles at pc_f=0x10 -> pc_f holds at 0x10, valid_d=0 and instr_d=0x00000013 for 3 cycles, stall_cnt=3, then the instruction at 0x10 is captured.
- Stall: stall_f=stall_d=1 for 2 cycles at pc_f=0x20 -> pc_f, instr_d and pc_d unchanged for 2 cycles; stall_cnt unchanged.
- Flush beats stall: flush_d=1, stall_f=1, stall_d=1, pc_next=0x400 -> after the edge pc_f=0x400 and valid_d=0.
- Wrap and saturation: pc_f=0xFFFF_FFFC -> pc_plus4=0x0; hold imem_valid=0 for 70000 cycles -> stall_cnt=0xFFFF.
- Async reset mid-run at pc_f=0x80 with valid_d=1 -> pc_f=RESET_PC and valid_d=0 before the next clk edge.

Source files
------------

// File: rtl/if_stage_pc_unit.sv
// Instruction-fetch stage: program counter, imem request handshake and the IF/ID register.
// Stall, flush and memory wait states are resolved here so decode sees a clean instr/valid pair.
module if_stage_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_f,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [15:0] stall_cnt
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e      state_q;
  logic        run;
  logic        fetch_ok;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // BOOT lasts exactly one cycle after reset so the first request is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
    end else begin
      state_q <= StRun;
    end
  end

  assign run      = (state_q == StRun);
  assign imem_req = run;
  assign fetch_ok = run & imem_valid;
  assign pc_plus4 = fetch_pc_q + 32'd4;

  // Flush redirects even through a stall or a memory wait state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (run) begin
      if (flush_d) begin
        fetch_pc_d = pc_next;
      end else if (!stall_f && fetch_ok) begin
        fetch_pc_d = pc_next;
      end
    end
  end

  always_comb begin
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    if (flush_d) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (stall_d) begin
      id_valid_d = id_valid_q;
    end else if (fetch_ok) begin
      id_instr_d = imem_rdata;
      id_pc_d    = fetch_pc_q;
      id_pc4_d   = pc_plus4;
      id_valid_d = 1'b1;
    end else begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end
  end

  // Only memory-induced losses count; hazard stalls are not the memory's fault.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (run && !imem_valid && !stall_f && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      id_instr_q  <= NOP_INSTR;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_f       = fetch_pc_q;
  assign instr_d    = id_instr_q;
  assign pc_d       = id_pc_q;
  assign pc_plus4_d = id_pc4_q;
  assign valid_d    = id_valid_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_if_stage_pc_unit.sv
// Self-checking bench for if_stage_pc_unit: a reference model pushes expected IF/ID
// contents to a scoreboard queue when a fetch is driven, popped when the DUT captures it.
module tb_if_stage_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] pc_f;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [15:0] stall_cnt;

  logic        redirect;
  logic [31:0] target;

  if_stage_pc_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_next   (pc_next),
    .pc_plus4  (pc_plus4),
    .pc_f      (pc_f),
    .imem_req  (imem_req),
    .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .stall_f   (stall_f),
    .stall_d   (stall_d),
    .flush_d   (flush_d),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc_plus4_d(pc_plus4_d),
    .valid_d   (valid_d),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  assign imem_rdata = instr_of(pc_f);
  assign pc_next    = redirect ? target : pc_f + 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [15:0] m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Advance the model by one edge using the current inputs, then tick the DUT.
  task automatic cycle(output bit cap);
    logic [31:0] nxt;
    logic [31:0] npc;
    logic [15:0] ncnt;
    bit          fetch;
    bit          nv;
    nxt   = redirect ? target : m_pc + 32'd4;
    fetch = m_run && imem_valid;
    cap   = 1'b0;
    npc   = m_pc;
    if (m_run) begin
      if (flush_d) npc = nxt;
      else if (!stall_f && fetch) npc = nxt;
    end
    nv = m_valid;
    if (flush_d) nv = 1'b0;
    else if (stall_d) nv = m_valid;
    else if (fetch) begin
      nv  = 1'b1;
      cap = 1'b1;
      sb.push_back('{instr: instr_of(m_pc), pc: m_pc, pc4: m_pc + 32'd4});
    end else nv = 1'b0;
    ncnt = m_cnt;
    if (m_run && !imem_valid && !stall_f && m_cnt != 16'hFFFF) ncnt = m_cnt + 16'd1;
    @(posedge clk);
    #1;
    m_run   = 1'b1;
    m_pc    = npc;
    m_valid = nv;
    m_cnt   = ncnt;
    if (cap) cur = sb.pop_front();
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_pc    = RST_PC;
    m_valid = 1'b0;
    m_cnt   = 16'd0;
    sb.delete();
  endtask

  task automatic release_ctrl();
    flush_d  = 1'b0;
    redirect = 1'b0;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
  endtask

  task automatic test_reset();
    bit cap;
    rst = 1'b1; imem_valid = 1'b1; target = 32'd0;
    release_ctrl();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (pc_f !== RST_PC) begin n_bad++; $display("FAIL rst_pc: got %h want %h", pc_f, RST_PC); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (valid_d !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_d); end
    n_cmp++; if (instr_d !== NOP) begin n_bad++; $display("FAIL rst_instr: got %h want %h", instr_d, NOP); end
    n_cmp++; if (pc_d !== 32'd0 || pc_plus4_d !== 32'd0) begin
      n_bad++; $display("FAIL rst_pcd: got %h/%h want 0/0", pc_d, pc_plus4_d);
    end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %h want 0", stall_cnt); end
    @(negedge clk) rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL boot_req: got %b want 0", imem_req); end
    cycle(cap);
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL run_req: got %b want 1", imem_req); end
    n_cmp++; if (pc_f !== RST_PC) begin n_bad++; $display("FAIL boot_pc: got %h want %h", pc_f, RST_PC); end
    n_cmp++; if (valid_d !== 1'b0) begin n_bad++; $display("FAIL boot_valid: got %b want 0", valid_d); end
    for (int i = 0; i < 3; i++) begin
      cycle(cap);
      n_cmp++; if (pc_f !== RST_PC + 32'd4 * (i + 1)) begin
        n_bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_f, RST_PC + 32'd4 * (i + 1));
      end
      n_cmp++; if (valid_d !== 1'b1 || !cap) begin
        n_bad++; $display("FAIL seq_valid[%0d]: got %b want 1", i, valid_d);
      end
      n_cmp++; if (instr_d !== cur.instr || pc_d !== cur.pc || pc_plus4_d !== cur.pc4) begin
        n_bad++; $display("FAIL seq_ifid[%0d]: got %h/%h/%h want %h/%h/%h", i, instr_d, pc_d,
                          pc_plus4_d, cur.instr, cur.pc, cur.pc4);
      end
    end
  endtask

  task automatic test_wait_states();
    bit cap;
    flush_d = 1'b1; redirect = 1'b1; target = 32'h10;
    cycle(cap);
    release_ctrl();
    n_cmp++; if (pc_f !== 32'h10 || valid_d !== 1'b0) begin
      n_bad++; $display("FAIL redirect_10: got pc %h valid %b want 00000010 0", pc_f, valid_d);
    end
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(cap);
      n_cmp++; if (pc_f !== 32'h10 || valid_d !== 1'b0 || instr_d !== NOP) begin
        n_bad++; $display("FAIL wait[%0d]: got pc %h valid %b instr %h want 00000010 0 %h",
                          i, pc_f, valid_d, instr_d, NOP);
      end
    end
    n_cmp++; if (stall_cnt !== 16'd3 || stall_cnt !== m_cnt) begin
      n_bad++; $display("FAIL wait_cnt: got %0d want 3", stall_cnt);
    end
    imem_valid = 1'b1;
    cycle(cap);
    n_cmp++; if (valid_d !== 1'b1 || instr_d !== cur.instr || pc_d !== 32'h10) begin
      n_bad++; $display("FAIL wait_capture: got %b %h %h want 1 %h 00000010", valid_d, instr_d,
                        pc_d, cur.instr);
    end
  endtask

  task automatic test_stall();
    bit cap;
    logic [15:0] cnt0;
    flush_d = 1'b1; redirect = 1'b1; target = 32'h1C;
    cycle(cap);
    release_ctrl();
    cycle(cap);
    cnt0 = m_cnt;
    n_cmp++; if (pc_f !== 32'h20 || pc_d !== 32'h1C) begin
      n_bad++; $display("FAIL stall_setup: got pc %h pc_d %h want 00000020 0000001c", pc_f, pc_d);
    end
    stall_f = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      imem_valid = (i == 1);
      cycle(cap);
      n_cmp++; if (pc_f !== 32'h20 || pc_d !== 32'h1C || instr_d !== instr_of(32'h1C)
                   || valid_d !== 1'b1) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got %h %h %h %b want 00000020 0000001c %h 1",
                          i, pc_f, pc_d, instr_d, valid_d, instr_of(32'h1C));
      end
      n_cmp++; if (stall_cnt !== cnt0) begin
        n_bad++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, stall_cnt, cnt0);
      end
    end
    release_ctrl();
    imem_valid = 1'b1;
    cycle(cap);
    n_cmp++; if (pc_f !== 32'h24 || pc_d !== cur.pc || instr_d !== cur.instr) begin
      n_bad++; $display("FAIL stall_release: got %h %h %h want 00000024 %h %h", pc_f, pc_d,
                        instr_d, cur.pc, cur.instr);
    end
  endtask

  task automatic test_flush_beats_stall();
    bit cap;
    flush_d = 1'b1; stall_f = 1'b1; stall_d = 1'b1; redirect = 1'b1; target = 32'h400;
    cycle(cap);
    release_ctrl();
    n_cmp++; if (pc_f !== 32'h400 || valid_d !== 1'b0 || instr_d !== NOP) begin
      n_bad++; $display("FAIL flush_stall: got %h %b %h want 00000400 0 %h", pc_f, valid_d,
                        instr_d, NOP);
    end
    cycle(cap);
    n_cmp++; if (valid_d !== 1'b1 || pc_d !== 32'h400 || instr_d !== cur.instr) begin
      n_bad++; $display("FAIL flush_target: got %b %h %h want 1 00000400 %h", valid_d, pc_d,
                        instr_d, cur.instr);
    end
  endtask

  task automatic test_wrap();
    bit cap;
    flush_d = 1'b1; redirect = 1'b1; target = 32'hFFFF_FFFC;
    cycle(cap);
    release_ctrl();
    n_cmp++; if (pc_plus4 !== 32'd0) begin
      n_bad++; $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4);
    end
    cycle(cap);
    n_cmp++; if (pc_f !== 32'd0 || pc_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'd0
                 || pc_plus4_d !== cur.pc4) begin
      n_bad++; $display("FAIL wrap_ifid: got %h %h %h want 00000000 fffffffc 00000000", pc_f,
                        pc_d, pc_plus4_d);
    end
  endtask

  task automatic test_async_reset();
    bit cap;
    flush_d = 1'b1; redirect = 1'b1; target = 32'h7C;
    cycle(cap);
    release_ctrl();
    cycle(cap);
    n_cmp++; if (pc_f !== 32'h80 || valid_d !== 1'b1) begin
      n_bad++; $display("FAIL areset_setup: got %h %b want 00000080 1", pc_f, valid_d);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc_f !== RST_PC || valid_d !== 1'b0 || instr_d !== NOP || imem_req !== 1'b0
                 || stall_cnt !== 16'd0) begin
      n_bad++; $display("FAIL areset: got %h %b %h %b %h want %h 0 %h 0 0000", pc_f, valid_d,
                        instr_d, imem_req, stall_cnt, RST_PC, NOP);
    end
    model_reset();
    @(negedge clk) rst = 1'b0;
    cycle(cap);
    n_cmp++; if (pc_f !== RST_PC || imem_req !== 1'b1 || valid_d !== 1'b0) begin
      n_bad++; $display("FAIL areset_boot: got %h %b %b want %h 1 0", pc_f, imem_req, valid_d,
                        RST_PC);
    end
  endtask

  task automatic test_saturation();
    bit cap;
    imem_valid = 1'b0;
    for (int i = 0; i < 70000; i++) cycle(cap);
    n_cmp++; if (stall_cnt !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_cnt: got %h want ffff", stall_cnt);
    end
    n_cmp++; if (pc_f !== m_pc || valid_d !== 1'b0) begin
      n_bad++; $display("FAIL sat_hold: got %h %b want %h 0", pc_f, valid_d, m_pc);
    end
    imem_valid = 1'b1;
    cycle(cap);
    n_cmp++; if (valid_d !== 1'b1 || pc_d !== RST_PC || stall_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_resume: got %b %h %h want 1 %h ffff", valid_d, pc_d,
                        stall_cnt, RST_PC);
    end
    n_cmp++; if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_stall();
    test_flush_beats_stall();
    test_wrap();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
